axis_frame_arbiter: RTL and testbench
=====================================

// Module: axis_frame_arbiter
// PURPOSE
//  Frame-granular round-robin arbiter sharing one AXI-Stream image sink (video-style
//  AXIS: tuser=SOF, tlast=EOL) between NUM_SRC image sources.
//  Grant is locked for a whole frame: from the SOF beat through the EOL beat of line
//  LINES_PER_FRAME. One register stage on the output. Sits between sources and
//  pipelined_reg / axis_image_vip.
// PARAMETERS
//  NUM_SRC          2   number of requesting sources (>=2)
//  DATA_BYTES       1   bytes per beat, all ports
//  LINES_PER_FRAME  4   EOL (tlast) beats per frame (>=1)
// PORTS
//  clk_i           in   1                     clock, rising edge
//  rstn_i          in   1                     reset, asynchronous, active-low
//  axis_s_data_i   in   NUM_SRC*DATA_BYTES*8  source data, src k at [k*DATA_BYTES*8 +: DATA_BYTES*8]
//  axis_s_valid_i  in   NUM_SRC               per-source tvalid
//  axis_s_ready_o  out  NUM_SRC               per-source tready
//  axis_s_last_i   in   NUM_SRC               per-source tlast (EOL)
//  axis_s_user_i   in   NUM_SRC               per-source tuser (SOF)
//  axis_m_data_o   out  DATA_BYTES*8          sink data
//  axis_m_valid_o  out  1                     sink tvalid
//  axis_m_ready_i  in   1                     sink tready
//  axis_m_last_o   out  1                     sink tlast
//  axis_m_user_o   out  1                     sink tuser
//  grant_o         out  max(1,$clog2(NUM_SRC)) index of locked source (valid when busy_o)
//  busy_o          out  1                     1 while in LOCK
//  drop_o          out  1                     1-cycle pulse: misaligned beat discarded in IDLE
//  err_o           out  1                     1-cycle pulse: SOF accepted mid-frame
// BEHAVIOUR
//  Reset (async, rstn_i=0): state=IDLE, ptr=NUM_SRC-1, line_cnt=0; axis_m_*_o=0,
//   axis_s_ready_o=0, grant_o=0, busy_o=0, drop_o=0, err_o=0.
//   Reset mid-frame discards the output register and the partial frame; no beat survives.
//  FSM IDLE:
//   - Requester k = axis_s_valid_i[k] & axis_s_user_i[k].
//   - Winner = first requester scanning ptr+1, ptr+2, ... (mod NUM_SRC).
//   - Any requester -> LOCK next cycle; grant_o=winner, ptr=winner, line_cnt=0.
//     No beat is accepted in the IDLE cycle.
//   - axis_s_ready_o[k]=valid[k]&~user[k]. Misaligned beats are dropped;
//     drop_o pulses the next cycle if any beat was dropped.
//  FSM LOCK:
//   - g=grant_o. Output register free: fr = ~axis_m_valid_o | axis_m_ready_i.
//   - axis_s_ready_o[g]=fr; all other ready bits 0 (non-granted sources stall).
//   - Accept = valid[g] & fr: register loads data/last/user of g, axis_m_valid_o=1.
//   - fr & ~valid[g]: axis_m_valid_o cleared.
//   - Output holds stable while axis_m_valid_o & ~axis_m_ready_i (AXIS rule).
//   - Accepted beat with last=1: line_cnt++. If line_cnt==LINES_PER_FRAME-1, FSM -> IDLE
//     next cycle and the register drains normally.
//   - Accepted beat with user=1 other than the first beat of the frame: forwarded
//     unchanged, err_o pulses, line_cnt unaffected.
//  Throughput: 1 beat/cycle inside a frame. Latency: 1 cycle source accept -> axis_m_valid_o.
//   Frame-to-frame gap: 1 IDLE cycle.
//  Simultaneous EOL accept and new SOF request: new request is evaluated in the following
//   IDLE cycle only. The rotation order is used and a single requester may re-win.
//  Widths: line_cnt is $clog2(LINES_PER_FRAME+1) bits; ptr and grant wrap modulo NUM_SRC.
// TESTING
//  1 Single src0, 2x4 frame (8 beats, data 0..7), sink ready=1 -> out 0..7; user on beat 0;
//    last on beats 1,3,5,7; busy_o low 1 cycle after the last accept.
//  2 src0,src1 both SOF-valid every cycle after reset -> frames alternate src0,src1,src0;
//    no beat interleaving inside a frame.
//  3 Sink ready toggles 1010 during a frame -> no loss or duplication; data stable while stalled;
//    beat count 8 per frame.
//  4 src1 presents 3 beats with user=0 while IDLE -> 3 accepted-and-dropped, 3 drop_o pulses,
//    no output; then SOF -> frame passes.
//  5 src0 asserts user on beat 5 of a frame -> beat forwarded, err_o pulses once,
//    frame still ends after the 4th EOL.
//  6 rstn_i low for 2 cycles at beat 3 -> all outputs 0 immediately; next frame from src0
//    passes intact.

Source files
------------

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter
//   Frame-granular round-robin arbiter that shares one AXI-Stream video sink
//   (tuser = start of frame, tlast = end of line) between NUM_SRC sources.
//   A source wins on a SOF beat and keeps the grant until the EOL beat of line
//   LINES_PER_FRAME has been accepted. The sink side has one register stage.
//
// Ports
//   clk_i, rstn_i   clock (rising edge), asynchronous active-low reset
//   axis_s_*        per-source slave streams, source k data at [k*DW +: DW]
//   axis_m_*        registered master stream toward the sink
//   grant_o         index of the locked source (meaningful while busy_o)
//   busy_o          high while a frame is locked
//   drop_o          one-cycle pulse: a non-SOF beat was discarded while idle
//   err_o           one-cycle pulse: a SOF beat arrived in the middle of a frame
module axis_frame_arbiter #(
  parameter int NUM_SRC         = 2,
  parameter int DATA_BYTES      = 1,
  parameter int LINES_PER_FRAME = 4
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic [NUM_SRC*DATA_BYTES*8-1:0]  axis_s_data_i,
  input  logic [NUM_SRC-1:0]               axis_s_valid_i,
  output logic [NUM_SRC-1:0]               axis_s_ready_o,
  input  logic [NUM_SRC-1:0]               axis_s_last_i,
  input  logic [NUM_SRC-1:0]               axis_s_user_i,
  output logic [DATA_BYTES*8-1:0]          axis_m_data_o,
  output logic                             axis_m_valid_o,
  input  logic                             axis_m_ready_i,
  output logic                             axis_m_last_o,
  output logic                             axis_m_user_o,
  output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] grant_o,
  output logic                             busy_o,
  output logic                             drop_o,
  output logic                             err_o
);

  localparam int DW  = DATA_BYTES * 8;
  localparam int GW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LCW = $clog2(LINES_PER_FRAME + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [LCW-1:0]    line_cnt_q, line_cnt_d;
  logic              first_q, first_d;
  logic [DW-1:0]     m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              m_user_q, m_user_d;
  logic              drop_q, drop_d;
  logic              err_q, err_d;

  logic [NUM_SRC-1:0] req_s;
  logic [NUM_SRC-1:0] s_ready_s;
  logic [GW:0]        win_s;
  logic               fr_s;
  logic [DW-1:0]      g_data_s;
  logic               g_valid_s;
  logic               g_last_s;
  logic               g_user_s;

  // Round-robin pick starting after ptr: returns {found, index}. The scan runs
  // from the farthest candidate back to the nearest so the nearest one sticks.
  function automatic logic [GW:0] pick_winner(input logic [NUM_SRC-1:0] req,
                                               input logic [GW-1:0]      ptr);
    logic [GW:0] res;
    int          idx;
    res = {(GW+1){1'b0}};
    for (int i = NUM_SRC; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NUM_SRC;
      res = req[idx] ? {1'b1, GW'(idx)} : res;
    end
    return res;
  endfunction

  assign req_s     = axis_s_valid_i & axis_s_user_i;
  assign win_s     = pick_winner(req_s, ptr_q);
  assign fr_s      = ~m_valid_q | axis_m_ready_i;
  assign g_data_s  = axis_s_data_i[int'(grant_q)*DW +: DW];
  assign g_valid_s = axis_s_valid_i[grant_q];
  assign g_last_s  = axis_s_last_i[grant_q];
  assign g_user_s  = axis_s_user_i[grant_q];

  // Next-state, grant bookkeeping, output register load and per-source ready.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    line_cnt_d = line_cnt_q;
    first_d    = first_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_user_d   = m_user_q;
    drop_d     = 1'b0;
    err_d      = 1'b0;
    s_ready_s  = {NUM_SRC{1'b0}};

    case (state_q)
      ST_IDLE: begin
        // Non-SOF beats are swallowed so a source cannot start mid-frame.
        s_ready_s = axis_s_valid_i & ~axis_s_user_i;
        drop_d    = |(axis_s_valid_i & ~axis_s_user_i);
        // The last beat of the previous frame may still be draining.
        m_valid_d = m_valid_q & ~axis_m_ready_i;
        if (win_s[GW]) begin
          state_d    = ST_LOCK;
          grant_d    = win_s[GW-1:0];
          ptr_d      = win_s[GW-1:0];
          line_cnt_d = {LCW{1'b0}};
          first_d    = 1'b1;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_LOCK: begin
        s_ready_s[grant_q] = fr_s;
        if (fr_s) begin
          if (g_valid_s) begin
            m_data_d  = g_data_s;
            m_last_d  = g_last_s;
            m_user_d  = g_user_s;
            m_valid_d = 1'b1;
            // Only the opening beat of the frame may legally carry SOF.
            if (first_q) begin
              first_d = 1'b0;
            end else begin
              err_d   = g_user_s;
            end
            if (g_last_s) begin
              if (line_cnt_q == LCW'(LINES_PER_FRAME - 1)) begin
                state_d    = ST_IDLE;
                line_cnt_d = {LCW{1'b0}};
              end else begin
                line_cnt_d = line_cnt_q + LCW'(1'b1);
              end
            end else begin
              line_cnt_d = line_cnt_q;
            end
          end else begin
            m_valid_d = 1'b0;
          end
        end else begin
          m_valid_d = m_valid_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, arbitration and output register flops.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= GW'(NUM_SRC - 1);
      grant_q    <= {GW{1'b0}};
      line_cnt_q <= {LCW{1'b0}};
      first_q    <= 1'b0;
      m_data_q   <= {DW{1'b0}};
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_user_q   <= 1'b0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      line_cnt_q <= line_cnt_d;
      first_q    <= first_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_user_q   <= m_user_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  // Ready is held low during reset even if sources are already presenting beats.
  assign axis_s_ready_o = s_ready_s & {NUM_SRC{rstn_i}};
  assign axis_m_data_o  = m_data_q;
  assign axis_m_valid_o = m_valid_q;
  assign axis_m_last_o  = m_last_q;
  assign axis_m_user_o  = m_user_q;
  assign grant_o        = grant_q;
  assign busy_o         = (state_q == ST_LOCK);
  assign drop_o         = drop_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Scoreboard bench for axis_frame_arbiter (NUM_SRC=2, 1 byte, 4 lines/frame).
// Frames are queued per source; the expected sink beats are queued in the
// order the arbiter must deliver them and a negedge monitor compares.
module tb_axis_frame_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] s_data;
  logic [1:0]  s_valid, s_ready, s_last, s_user;
  logic [7:0]  m_data;
  logic        m_valid, m_ready, m_last, m_user;
  logic [0:0]  grant;
  logic        busy, drop, err;

  always #5 clk = ~clk;

  axis_frame_arbiter #(.NUM_SRC(2), .DATA_BYTES(1), .LINES_PER_FRAME(4)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .axis_s_data_i(s_data), .axis_s_valid_i(s_valid), .axis_s_ready_o(s_ready),
    .axis_s_last_i(s_last), .axis_s_user_i(s_user),
    .axis_m_data_o(m_data), .axis_m_valid_o(m_valid), .axis_m_ready_i(m_ready),
    .axis_m_last_o(m_last), .axis_m_user_o(m_user),
    .grant_o(grant), .busy_o(busy), .drop_o(drop), .err_o(err)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  typedef struct packed {
    beat_t b;
    logic  src;
    logic  eof;
  } exp_t;

  beat_t srcq0[$];
  beat_t srcq1[$];
  exp_t  expq[$];

  int    checks = 0;
  int    errors = 0;
  int    drop_cnt = 0;
  int    err_cnt = 0;
  int    out_cnt = 0;
  int    cyc = 0;
  bit    tog = 1'b0;
  bit    hs0 = 1'b0;
  bit    hs1 = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // 8-beat frame, EOL on odd beats, SOF on beat 0 and optionally on user_beat.
  task automatic push_frame(input int src, input logic [7:0] base, input int user_beat);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < 8; i++) begin
      b.data = base + 8'(i);
      b.last = (i % 2 == 1);
      b.user = (i == 0) || (i == user_beat);
      if (src == 0) srcq0.push_back(b);
      else          srcq1.push_back(b);
      e.b   = b;
      e.src = 1'(src);
      e.eof = (i == 7);
      expq.push_back(e);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((expq.size() != 0 || srcq0.size() != 0 || srcq1.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_drained_beats_left"}, 32'(expq.size()), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({name, "_m_data"},  32'(m_data),  32'd0);
    chk({name, "_m_last"},  32'(m_last),  32'd0);
    chk({name, "_m_user"},  32'(m_user),  32'd0);
    chk({name, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({name, "_grant"},   32'(grant),   32'd0);
    chk({name, "_busy"},    32'(busy),    32'd0);
    chk({name, "_drop"},    32'(drop),    32'd0);
    chk({name, "_err"},     32'(err),     32'd0);
  endtask

  // Source and sink-ready driver: pops handshaken beats, presents queue heads.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (hs0 && srcq0.size() > 0) void'(srcq0.pop_front());
    if (hs1 && srcq1.size() > 0) void'(srcq1.pop_front());
    hs0 = 1'b0;
    hs1 = 1'b0;
    if (srcq0.size() > 0) begin
      s_valid[0] = 1'b1; s_data[7:0] = srcq0[0].data;
      s_last[0]  = srcq0[0].last; s_user[0] = srcq0[0].user;
    end else begin
      s_valid[0] = 1'b0; s_data[7:0] = 8'h00; s_last[0] = 1'b0; s_user[0] = 1'b0;
    end
    if (srcq1.size() > 0) begin
      s_valid[1] = 1'b1; s_data[15:8] = srcq1[0].data;
      s_last[1]  = srcq1[0].last; s_user[1] = srcq1[0].user;
    end else begin
      s_valid[1] = 1'b0; s_data[15:8] = 8'h00; s_last[1] = 1'b0; s_user[1] = 1'b0;
    end
    m_ready = tog ? cyc[0] : 1'b1;
  end

  // Monitor: records source handshakes and checks every sink beat.
  always @(negedge clk) begin
    exp_t e;
    hs0 = s_valid[0] & s_ready[0];
    hs1 = s_valid[1] & s_ready[1];
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (drop) drop_cnt++;
      if (err)  err_cnt++;
      if (prev_stall) begin
        chk("stall_stable", 32'({m_valid, m_data, m_last, m_user}), 32'({1'b1, held}));
      end else if (m_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h, required no beat", m_data);
        end else begin
          e = expq[0];
          chk("beat_data_last_user", 32'({m_data, m_last, m_user}), 32'(e.b));
          chk("beat_grant", 32'(grant), 32'(e.src));
          chk("beat_busy", 32'(busy), 32'(!e.eof));
        end
      end
      if (m_valid && m_ready && expq.size() > 0) begin
        void'(expq.pop_front());
        out_cnt++;
      end
      prev_stall = m_valid & ~m_ready;
      held = beat_t'({m_data, m_last, m_user});
    end
  end

  initial begin
    int d0;
    int e0;
    int n0;
    int n;
    rstn = 1'b0;
    s_valid = 2'b00; s_data = 16'h0000; s_last = 2'b00; s_user = 2'b00;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk_reset_outputs("reset");
    rstn = 1'b1;

    // Both sources request right after reset: src0, src1, src0.
    push_frame(0, 8'h10, 0);
    push_frame(1, 8'h20, 0);
    push_frame(0, 8'h30, 0);
    wait_done("alternate", 200);

    // Single source, sink always ready.
    push_frame(0, 8'h00, 0);
    wait_done("single", 100);
    chk("single_err_count", 32'(err_cnt), 32'd0);

    // Sink ready toggles during the frame.
    tog = 1'b1;
    push_frame(0, 8'h40, 0);
    wait_done("toggle", 200);
    tog = 1'b0;

    // Three misaligned beats on src1 while idle, then a proper frame.
    d0 = drop_cnt;
    for (int i = 0; i < 3; i++) srcq1.push_back(beat_t'({8'hE0 + 8'(i), 1'b0, 1'b0}));
    push_frame(1, 8'h50, 0);
    wait_done("drop", 100);
    chk("drop_pulses", 32'(drop_cnt - d0), 32'd3);

    // SOF on beat 5 inside a frame.
    e0 = err_cnt;
    push_frame(0, 8'h60, 5);
    wait_done("midsof", 100);
    chk("midsof_err_pulses", 32'(err_cnt - e0), 32'd1);

    // Reset once beats 0..3 of a frame have been delivered.
    n0 = out_cnt;
    push_frame(0, 8'h70, 0);
    n = 0;
    while (out_cnt - n0 < 4 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("midreset_reached_beat3", 32'(n < 100), 32'd1);
    #2;
    rstn = 1'b0;
    srcq0.delete();
    srcq1.delete();
    expq.delete();
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    push_frame(0, 8'h80, 0);
    wait_done("after_reset", 100);

    chk("total_err_pulses", 32'(err_cnt), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
